image_buffer: RTL and testbench

- Byte-wide image store between the SPI command FSM (writer) and the BNN core (reader).
- Accepts IMG_BYTE_SIZE bytes sequentially through a request/ready handshake and reports full/empty status back to the FSM.
- Serves random-access byte reads to the BNN with 1-cycle latency.
- Performs a multi-cycle zeroing sweep on a clear command and signals completion through buffer_empty.

---
 rtl/bnn_ocr_pkg.sv | 19 +
 rtl/image_buffer_if.sv | 31 +++
 rtl/image_ram.sv | 29 ++
 rtl/image_buffer.sv | 129 ++++++++++++
 tb/tb_image_buffer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_ocr_pkg.sv
// Shared constants and types for the BNN OCR datapath: image geometry,
// address width and the image buffer state encoding.
package bnn_ocr_pkg;

  localparam int IMG_BYTE_SIZE = 113;
  localparam int ADDR_W        = $clog2(IMG_BYTE_SIZE);

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t LAST_ADDR = addr_t'(IMG_BYTE_SIZE - 1);
  localparam addr_t END_ADDR  = addr_t'(IMG_BYTE_SIZE);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_FILL,
    S_FULL
  } buf_state_e;

endpackage

// File: rtl/image_buffer_if.sv
// Write handshake, status and BNN read channel of the image buffer.
// master = FSM/BNN side, slave = image_buffer.
interface image_buffer_if #(
  parameter int ADDR_W = 7
);

  logic              buffer_write_request;
  logic [7:0]        buffer_write_data;
  logic              buffer_write_ready;
  logic              buffer_full;
  logic              buffer_empty;
  logic [ADDR_W-1:0] byte_count;
  logic              overflow_err;
  logic              bnn_rd_en;
  logic [ADDR_W-1:0] bnn_rd_addr;
  logic [7:0]        bnn_rd_data;
  logic              bnn_rd_valid;

  modport master (
    output buffer_write_request, buffer_write_data, bnn_rd_en, bnn_rd_addr,
    input  buffer_write_ready, buffer_full, buffer_empty, byte_count,
           overflow_err, bnn_rd_data, bnn_rd_valid
  );

  modport slave (
    input  buffer_write_request, buffer_write_data, bnn_rd_en, bnn_rd_addr,
    output buffer_write_ready, buffer_full, buffer_empty, byte_count,
           overflow_err, bnn_rd_data, bnn_rd_valid
  );

endinterface

// File: rtl/image_ram.sv
// 1W/1R synchronous byte RAM. Reads return the pre-write contents when
// the same address is written in the same cycle.
module image_ram #(
  parameter int DEPTH = 113,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: no reset on the array or read register so this maps to block RAM;
  // the owner zeroes contents with a sweep and masks rdata until valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : 8'h00;
    end
  end

endmodule

// File: rtl/image_buffer.sv
// Byte-wide image store: sequential fill from the command FSM, random-access
// reads for the BNN core, and a multi-cycle zeroing sweep on clear.
module image_buffer
  import bnn_ocr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  image_buffer_if.slave bus
);

  buf_state_e state;
  addr_t      clr_ptr;
  addr_t      wr_ptr;
  addr_t      byte_count;
  logic       clear_q;
  logic       full_q;
  logic       empty_q;
  logic       overflow_q;
  logic       rd_valid_q;
  logic       rd_zero_q;

  logic       clear_rise;
  logic       fill_write;
  logic       blocked_write;

  logic       ram_we;
  addr_t      ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  assign clear_rise    = clear & ~clear_q;
  assign fill_write    = (state == S_FILL) & bus.buffer_write_request & ~clear_rise;
  assign blocked_write = (state != S_FILL) & bus.buffer_write_request & ~clear_rise;

  // The sweep owns the single write port whenever it is running.
  always_comb begin
    ram_we    = fill_write;
    ram_waddr = wr_ptr;
    ram_wdata = bus.buffer_write_data;
    if (state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = 8'h00;
    end
  end

  image_ram #(
    .DEPTH (IMG_BYTE_SIZE),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (bus.bnn_rd_en),
    .raddr (bus.bnn_rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLEAR;
      clr_ptr    <= '0;
      wr_ptr     <= '0;
      byte_count <= '0;
      clear_q    <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      clear_q    <= clear;
      rd_valid_q <= bus.bnn_rd_en;
      rd_zero_q  <= (state == S_CLEAR) || (bus.bnn_rd_addr >= END_ADDR);

      if (blocked_write) begin
        overflow_q <= 1'b1;
      end

      if (clear_rise) begin
        state      <= S_CLEAR;
        clr_ptr    <= '0;
        wr_ptr     <= '0;
        byte_count <= '0;
        full_q     <= 1'b0;
        empty_q    <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        case (state)
          S_CLEAR: begin
            if (clr_ptr == LAST_ADDR) begin
              state      <= S_FILL;
              clr_ptr    <= '0;
              wr_ptr     <= '0;
              byte_count <= '0;
              empty_q    <= 1'b1;
            end else begin
              clr_ptr <= clr_ptr + addr_t'(1);
            end
          end
          S_FILL: begin
            if (fill_write) begin
              wr_ptr     <= wr_ptr + addr_t'(1);
              byte_count <= byte_count + addr_t'(1);
              empty_q    <= 1'b0;
              if (byte_count == LAST_ADDR) begin
                state  <= S_FULL;
                full_q <= 1'b1;
              end
            end
          end
          S_FULL: ;
          default: state <= S_CLEAR;
        endcase
      end
    end
  end

  assign bus.buffer_write_ready = (state == S_FILL);
  assign bus.buffer_full        = full_q;
  assign bus.buffer_empty       = empty_q;
  assign bus.byte_count         = byte_count;
  assign bus.overflow_err       = overflow_q;
  assign bus.bnn_rd_valid       = rd_valid_q;
  assign bus.bnn_rd_data        = (rd_valid_q && !rd_zero_q) ? ram_rdata : 8'h00;

endmodule

// File: tb/tb_image_buffer.sv
// Self-checking bench for image_buffer: directed vector table, test-plan
// sequences and randomized traffic against a byte-array reference model.
module tb_image_buffer;
  import bnn_ocr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  image_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  image_buffer dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stored bytes, bytes written, sweep cycles remaining.
  logic [7:0] m_mem [IMG_BYTE_SIZE];
  int         m_count;
  int         m_sweep_left;
  bit         m_ovf;
  bit         m_clear_prev;
  bit         m_rd_valid;
  logic [7:0] m_rd_data;

  typedef struct {
    bit         req;
    logic [7:0] data;
    bit         rd_en;
    logic [6:0] addr;
    int         exp_count;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    if (rst) begin
      m_count      = 0;
      m_sweep_left = IMG_BYTE_SIZE;
      m_ovf        = 0;
      m_clear_prev = 0;
      m_rd_valid   = 0;
      m_rd_data    = 8'h00;
      for (int i = 0; i < IMG_BYTE_SIZE; i++) m_mem[i] = 8'h00;
    end else begin
      rise         = clear && !m_clear_prev;
      m_clear_prev = clear;
      // read sees the contents before this cycle's write
      m_rd_valid = bus.bnn_rd_en;
      m_rd_data  = 8'h00;
      if (bus.bnn_rd_en && m_sweep_left == 0 && int'(bus.bnn_rd_addr) < IMG_BYTE_SIZE)
        m_rd_data = m_mem[bus.bnn_rd_addr];
      if (rise) begin
        m_sweep_left = IMG_BYTE_SIZE;
        m_count      = 0;
        m_ovf        = 0;
        for (int i = 0; i < IMG_BYTE_SIZE; i++) m_mem[i] = 8'h00;
      end else if (m_sweep_left > 0) begin
        if (bus.buffer_write_request) m_ovf = 1;
        m_sweep_left--;
      end else if (m_count < IMG_BYTE_SIZE) begin
        if (bus.buffer_write_request) begin
          m_mem[m_count] = bus.buffer_write_data;
          m_count++;
        end
      end else begin
        if (bus.buffer_write_request) m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("ready",    int'(bus.buffer_write_ready), int'(m_sweep_left == 0 && m_count < IMG_BYTE_SIZE));
    check("full",     int'(bus.buffer_full),        int'(m_count == IMG_BYTE_SIZE));
    check("empty",    int'(bus.buffer_empty),       int'(m_sweep_left == 0 && m_count == 0));
    check("count",    int'(bus.byte_count),         m_count);
    check("overflow", int'(bus.overflow_err),       int'(m_ovf));
    check("rd_valid", int'(bus.bnn_rd_valid),       int'(m_rd_valid));
    check("rd_data",  int'(bus.bnn_rd_data),        int'(m_rd_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    bus.buffer_write_request = 1'b0;
    bus.buffer_write_data    = 8'h00;
    bus.bnn_rd_en            = 1'b0;
    bus.bnn_rd_addr          = '0;
  endtask

  // Counts ticks until buffer_empty rises (bounded), returns -1 on timeout.
  task automatic ticks_to_empty(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (bus.buffer_empty && n < 0) n = k;
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < IMG_BYTE_SIZE; i++) begin
      bus.bnn_rd_en   = 1'b1;
      bus.bnn_rd_addr = addr_t'(i);
      tick();
      check(tag, int'(bus.bnn_rd_data), 0);
    end
    idle();
  endtask

  initial begin
    int n;
    int first;
    int rises;
    bit prev_empty;

    vecs[0] = '{1'b1, 8'h11, 1'b1, 7'd0,   1, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 8'h22, 1'b1, 7'd0,   2, 1'b1, 8'h11};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 7'd1,   2, 1'b1, 8'h22};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 7'd120, 2, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 7'd0,   2, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 8'h33, 1'b1, 7'd2,   3, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 7'd2,   3, 1'b1, 8'h33};

    // Reset, then the power-up sweep
    rst   = 1'b1;
    clear = 1'b0;
    idle();
    tick();
    check("rst_ready", int'(bus.buffer_write_ready), 0);
    check("rst_full",  int'(bus.buffer_full), 0);
    check("rst_empty", int'(bus.buffer_empty), 0);
    check("rst_count", int'(bus.byte_count), 0);
    check("rst_valid", int'(bus.bnn_rd_valid), 0);
    rst = 1'b0;
    ticks_to_empty(IMG_BYTE_SIZE, first);
    check("reset_sweep_len", first, IMG_BYTE_SIZE);
    check("idle_ready", int'(bus.buffer_write_ready), 1);
    read_all_zero("idle_read_zero");

    // Directed vector table, including read-before-write
    for (int v = 0; v < 7; v++) begin
      bus.buffer_write_request = vecs[v].req;
      bus.buffer_write_data    = vecs[v].data;
      bus.bnn_rd_en            = vecs[v].rd_en;
      bus.bnn_rd_addr          = vecs[v].addr;
      tick();
      check($sformatf("vec%0d_count", v), int'(bus.byte_count),   vecs[v].exp_count);
      check($sformatf("vec%0d_valid", v), int'(bus.bnn_rd_valid), int'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v),  int'(bus.bnn_rd_data),  int'(vecs[v].exp_data));
    end
    idle();

    // Pulse clear to return to an empty buffer
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ticks_to_empty(IMG_BYTE_SIZE + 5, first);
    check("reclear_sweep_len", first, IMG_BYTE_SIZE);

    // Fill with addr ^ 0xA5
    for (int i = 0; i < IMG_BYTE_SIZE; i++) begin
      bus.buffer_write_request = 1'b1;
      bus.buffer_write_data    = 8'(i ^ 8'hA5);
      tick();
      if (i == 0) check("fill_empty_drop", int'(bus.buffer_empty), 0);
      if (i == IMG_BYTE_SIZE - 2) check("fill_not_full_yet", int'(bus.buffer_full), 0);
    end
    idle();
    check("fill_full",  int'(bus.buffer_full), 1);
    check("fill_count", int'(bus.byte_count), IMG_BYTE_SIZE);
    check("fill_ready", int'(bus.buffer_write_ready), 0);

    // Readback
    for (int i = 0; i < IMG_BYTE_SIZE; i++) begin
      bus.bnn_rd_en   = 1'b1;
      bus.bnn_rd_addr = addr_t'(i);
      tick();
      check("readback_valid", int'(bus.bnn_rd_valid), 1);
      check("readback_data",  int'(bus.bnn_rd_data), (i ^ 8'hA5) & 8'hFF);
    end
    bus.bnn_rd_addr = 7'd120;
    tick();
    check("read_oob", int'(bus.bnn_rd_data), 0);
    idle();
    tick();
    check("valid_pulse_end", int'(bus.bnn_rd_valid), 0);

    // Overflow in S_FULL
    bus.buffer_write_request = 1'b1;
    bus.buffer_write_data    = 8'hFF;
    tick();
    idle();
    check("ovf_set",   int'(bus.overflow_err), 1);
    check("ovf_count", int'(bus.byte_count), IMG_BYTE_SIZE);
    bus.bnn_rd_en = 1'b1;
    tick();
    idle();
    check("ovf_mem0", int'(bus.bnn_rd_data), 8'hA5);

    // Clear held high for 200 cycles: one sweep only
    clear      = 1'b1;
    rises      = 0;
    first      = -1;
    prev_empty = bus.buffer_empty;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.buffer_empty && !prev_empty) begin
        rises++;
        if (first < 0) first = k;
      end
      prev_empty = bus.buffer_empty;
    end
    clear = 1'b0;
    check("hold_sweep_len",   first, IMG_BYTE_SIZE);
    check("hold_single_sweep", rises, 1);
    check("hold_ovf_cleared", int'(bus.overflow_err), 0);
    read_all_zero("hold_read_zero");

    // Clear mid-fill coinciding with a write
    for (int i = 0; i < 40; i++) begin
      bus.buffer_write_request = 1'b1;
      bus.buffer_write_data    = 8'($urandom);
      tick();
    end
    check("mid_count40", int'(bus.byte_count), 40);
    clear                 = 1'b1;
    bus.buffer_write_data = 8'h77;
    tick();
    clear = 1'b0;
    idle();
    check("mid_no_ovf",  int'(bus.overflow_err), 0);
    check("mid_count0",  int'(bus.byte_count), 0);
    ticks_to_empty(IMG_BYTE_SIZE + 5, n);
    check("mid_sweep_len", n, IMG_BYTE_SIZE);
    for (int i = 0; i < IMG_BYTE_SIZE; i++) begin
      bus.buffer_write_request = 1'b1;
      bus.buffer_write_data    = 8'($urandom);
      tick();
    end
    idle();
    check("refill_full", int'(bus.buffer_full), 1);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      clear                    = ($urandom_range(0, 199) == 0);
      bus.buffer_write_request = 1'($urandom_range(0, 1));
      bus.buffer_write_data    = 8'($urandom);
      bus.bnn_rd_en            = 1'($urandom_range(0, 1));
      bus.bnn_rd_addr          = 7'($urandom_range(0, 127));
      tick();
    end
    clear = 1'b0;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
